// File: rtl/hazard_pipe_tracker_pkg.sv
// Shared definitions for the hazard pipe tracker slice: register-file
// geometry, writeback-source encodings and FP latency defaults.
package hazard_pipe_tracker_pkg;

  localparam int REG_W    = 5;
  localparam int WBSRC_W  = 2;
  localparam int NUM_REGS = 32;

  localparam logic [WBSRC_W-1:0] WBSRC_MEM = 2'd1;

  localparam int FP_SHORT_LAT_DEF = 2;
  localparam int FP_LONG_LAT_DEF  = 8;
  localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/hazard_pipe_tracker_fp_scoreboard.sv
// FP register scoreboard: one countdown counter per FP register. A counter
// is loaded with the producing op's latency when an FP write issues and
// counts down to 0, at which point the register file holds the result.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load_i          an FP write is issuing this cycle
//   load_long_i     the issuing FP write is long latency
//   dst_i           destination of the ID instruction (load target / WAW check)
//   fs_i, ft_i      FP sources of the ID instruction
//   fp_read_i       ID instruction reads fs_i/ft_i as FP sources
//   wr_float_i      ID instruction writes an FP destination
//   fp_stall_o      RAW or WAW hazard against a pending FP write
module hazard_pipe_tracker_fp_scoreboard
  import hazard_pipe_tracker_pkg::*;
#(
  parameter int FP_SHORT_LAT = FP_SHORT_LAT_DEF,
  parameter int FP_LONG_LAT  = FP_LONG_LAT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             load_long_i,
  input  logic [REG_W-1:0] dst_i,
  input  logic [REG_W-1:0] fs_i,
  input  logic [REG_W-1:0] ft_i,
  input  logic             fp_read_i,
  input  logic             wr_float_i,
  output logic             fp_stall_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_SHORT = CNT_W'(FP_SHORT_LAT);
  localparam logic [CNT_W-1:0] LAT_LONG  = CNT_W'(FP_LONG_LAT);

  logic [CNT_W-1:0] sb_q [NUM_REGS];
  logic [CNT_W-1:0] sb_d [NUM_REGS];

  // Next-state of every counter: a fresh load beats the decrement.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (load_i && (dst_i == REG_W'(i))) begin
        sb_d[i] = load_long_i ? LAT_LONG : LAT_SHORT;
      end else if (sb_q[i] != CNT_ZERO) begin
        sb_d[i] = sb_q[i] - CNT_ONE;
      end else begin
        sb_d[i] = sb_q[i];
      end
    end
  end

  // Counter array register; reset discards all pending FP writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb_q[i] <= CNT_ZERO;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // Hazard compare uses only registered counters and ID-stage fields, so it
  // cannot loop back through the bubble logic in the top.
  always_comb begin
    fp_stall_o = (fp_read_i  & ((sb_q[fs_i] != CNT_ZERO) | (sb_q[ft_i] != CNT_ZERO)))
               | (wr_float_i &  (sb_q[dst_i] != CNT_ZERO));
  end

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Hazard pipe tracker: carries ID destination metadata through the ID/EX and
// EX/MEM pipe registers for the forwarding unit, injects bubbles on stall or
// flush, and stalls ID on pending multi-cycle FP writes (FP results are never
// forwarded).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ID_Dst/Write/Float/FpLong/WBSrc  destination metadata of the ID instruction
//   ID_Fs/ID_Ft/ID_FpRead            FP sources of the ID instruction
//   fw_stall, flush                  load-use stall and branch/jump squash
//   EX_Dst/Write/Float, WBSrc        EX-stage metadata
//   MEM_Dst/Write/Float              MEM-stage metadata
//   fp_stall                         ID must hold on an FP RAW/WAW hazard
module hazard_pipe_tracker
  import hazard_pipe_tracker_pkg::*;
#(
  parameter int FP_SHORT_LAT = FP_SHORT_LAT_DEF,
  parameter int FP_LONG_LAT  = FP_LONG_LAT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   ID_Dst,
  input  logic               ID_Write,
  input  logic               ID_Float,
  input  logic               ID_FpLong,
  input  logic [WBSRC_W-1:0] ID_WBSrc,
  input  logic [REG_W-1:0]   ID_Fs,
  input  logic [REG_W-1:0]   ID_Ft,
  input  logic               ID_FpRead,
  input  logic               fw_stall,
  input  logic               flush,
  output logic [REG_W-1:0]   EX_Dst,
  output logic               EX_Write,
  output logic               EX_Float,
  output logic [WBSRC_W-1:0] WBSrc,
  output logic [REG_W-1:0]   MEM_Dst,
  output logic               MEM_Write,
  output logic               MEM_Float,
  output logic               fp_stall
);

  logic               bubble_s;
  logic               issue_s;
  logic               fp_stall_s;

  logic [REG_W-1:0]   ex_dst_q,   ex_dst_d;
  logic               ex_write_q, ex_write_d;
  logic               ex_float_q, ex_float_d;
  logic [WBSRC_W-1:0] ex_wbsrc_q, ex_wbsrc_d;
  logic [REG_W-1:0]   mem_dst_q;
  logic               mem_write_q;
  logic               mem_float_q;

  // Stall and flush collapse into a single bubble; nothing is queued.
  always_comb begin
    bubble_s = fw_stall | fp_stall_s | flush;
    issue_s  = ~bubble_s & ID_Write;
  end

  hazard_pipe_tracker_fp_scoreboard #(
    .FP_SHORT_LAT (FP_SHORT_LAT),
    .FP_LONG_LAT  (FP_LONG_LAT),
    .CNT_W        (CNT_W)
  ) u_fp_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .load_i      (issue_s & ID_Float),
    .load_long_i (ID_FpLong),
    .dst_i       (ID_Dst),
    .fs_i        (ID_Fs),
    .ft_i        (ID_Ft),
    .fp_read_i   (ID_FpRead),
    .wr_float_i  (ID_Write & ID_Float),
    .fp_stall_o  (fp_stall_s)
  );

  // ID/EX next state: a bubble clears every field.
  always_comb begin
    if (bubble_s) begin
      ex_dst_d   = {REG_W{1'b0}};
      ex_write_d = 1'b0;
      ex_float_d = 1'b0;
      ex_wbsrc_d = {WBSRC_W{1'b0}};
    end else begin
      ex_dst_d   = ID_Dst;
      ex_write_d = ID_Write;
      ex_float_d = ID_Float;
      ex_wbsrc_d = ID_WBSrc;
    end
  end

  // ID/EX and EX/MEM pipe registers; MEM copies EX unconditionally.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_dst_q    <= {REG_W{1'b0}};
      ex_write_q  <= 1'b0;
      ex_float_q  <= 1'b0;
      ex_wbsrc_q  <= {WBSRC_W{1'b0}};
      mem_dst_q   <= {REG_W{1'b0}};
      mem_write_q <= 1'b0;
      mem_float_q <= 1'b0;
    end else begin
      ex_dst_q    <= ex_dst_d;
      ex_write_q  <= ex_write_d;
      ex_float_q  <= ex_float_d;
      ex_wbsrc_q  <= ex_wbsrc_d;
      mem_dst_q   <= ex_dst_q;
      mem_write_q <= ex_write_q;
      mem_float_q <= ex_float_q;
    end
  end

  assign EX_Dst    = ex_dst_q;
  assign EX_Write  = ex_write_q;
  assign EX_Float  = ex_float_q;
  assign WBSrc     = ex_wbsrc_q;
  assign MEM_Dst   = mem_dst_q;
  assign MEM_Write = mem_write_q;
  assign MEM_Float = mem_float_q;
  assign fp_stall  = fp_stall_s;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Scoreboard bench for hazard_pipe_tracker: a driver applies one ID-stage
// input set per cycle, evaluates a behavioural model (pending FP writes kept
// as absolute ready-cycle numbers) and queues the expected response; a
// monitor compares fp_stall mid-cycle and EX/MEM after the next edge.
module tb_hazard_pipe_tracker;

  localparam int SHORT_LAT = 2;
  localparam int LONG_LAT  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Dst, ID_Fs, ID_Ft;
  logic       ID_Write, ID_Float, ID_FpLong, ID_FpRead;
  logic [1:0] ID_WBSrc;
  logic       fw_stall, flush;
  logic [4:0] EX_Dst, MEM_Dst;
  logic       EX_Write, EX_Float, MEM_Write, MEM_Float, fp_stall;
  logic [1:0] WBSrc;

  hazard_pipe_tracker dut (
    .clk(clk), .reset(reset),
    .ID_Dst(ID_Dst), .ID_Write(ID_Write), .ID_Float(ID_Float),
    .ID_FpLong(ID_FpLong), .ID_WBSrc(ID_WBSrc),
    .ID_Fs(ID_Fs), .ID_Ft(ID_Ft), .ID_FpRead(ID_FpRead),
    .fw_stall(fw_stall), .flush(flush),
    .EX_Dst(EX_Dst), .EX_Write(EX_Write), .EX_Float(EX_Float), .WBSrc(WBSrc),
    .MEM_Dst(MEM_Dst), .MEM_Write(MEM_Write), .MEM_Float(MEM_Float),
    .fp_stall(fp_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [4:0] ex_dst;
    logic       ex_w, ex_f;
    logic [1:0] wb;
    logic [4:0] mem_dst;
    logic       mem_w, mem_f;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges elapsed, first edge count at which each FP reg is
  // readable, and the model's current EX contents.
  int         cyc = 0;
  int         ready_at [32];
  logic [4:0] m_ex_dst = 5'd0;
  logic       m_ex_w = 1'b0, m_ex_f = 1'b0;
  logic [1:0] m_wb = 2'd0;

  int stall_cnt;

  function automatic logic pending(input logic [4:0] r);
    return cyc < ready_at[r];
  endfunction

  task automatic step(input logic rst, input logic [4:0] dst, input logic wr,
                      input logic fl, input logic lng, input logic [1:0] wb,
                      input logic [4:0] fs, input logic [4:0] ft, input logic frd,
                      input logic fw, input logic fls);
    exp_t e;
    logic st, bub;
    @(negedge clk);
    reset = rst; ID_Dst = dst; ID_Write = wr; ID_Float = fl; ID_FpLong = lng;
    ID_WBSrc = wb; ID_Fs = fs; ID_Ft = ft; ID_FpRead = frd;
    fw_stall = fw; flush = fls;
    st  = (frd & (pending(fs) | pending(ft))) | (wr & fl & pending(dst));
    bub = fw | st | fls;
    e.stall   = st;
    e.mem_dst = rst ? 5'd0 : m_ex_dst;
    e.mem_w   = rst ? 1'b0 : m_ex_w;
    e.mem_f   = rst ? 1'b0 : m_ex_f;
    if (rst || bub) begin
      e.ex_dst = 5'd0; e.ex_w = 1'b0; e.ex_f = 1'b0; e.wb = 2'd0;
    end else begin
      e.ex_dst = dst; e.ex_w = wr; e.ex_f = fl; e.wb = wb;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) ready_at[i] = 0;
    end else if (!bub && wr && fl) begin
      ready_at[dst] = cyc + 1 + (lng ? LONG_LAT : SHORT_LAT);
    end
    m_ex_dst = e.ex_dst; m_ex_w = e.ex_w; m_ex_f = e.ex_f; m_wb = e.wb;
    exp_q.push_back(e);
    cyc++;
    if (st) stall_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: fp_stall mid-low-phase, pipe registers just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        n_checks++;
        if (fp_stall !== e.stall) begin
          n_fail++;
          $display("FAIL fp_stall t=%0t got %b exp %b", $time, fp_stall, e.stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({EX_Dst, EX_Write, EX_Float, WBSrc} !== {e.ex_dst, e.ex_w, e.ex_f, e.wb}) begin
          n_fail++;
          $display("FAIL ex_stage t=%0t got dst=%0d w=%b f=%b wb=%0d exp dst=%0d w=%b f=%b wb=%0d",
                   $time, EX_Dst, EX_Write, EX_Float, WBSrc, e.ex_dst, e.ex_w, e.ex_f, e.wb);
        end
        n_checks++;
        if ({MEM_Dst, MEM_Write, MEM_Float} !== {e.mem_dst, e.mem_w, e.mem_f}) begin
          n_fail++;
          $display("FAIL mem_stage t=%0t got dst=%0d w=%b f=%b exp dst=%0d w=%b f=%b",
                   $time, MEM_Dst, MEM_Write, MEM_Float, e.mem_dst, e.mem_w, e.mem_f);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int wait_cnt;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    reset = 1'b1; ID_Dst = 5'd0; ID_Write = 1'b0; ID_Float = 1'b0; ID_FpLong = 1'b0;
    ID_WBSrc = 2'd0; ID_Fs = 5'd0; ID_Ft = 5'd0; ID_FpRead = 1'b0;
    fw_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then a mid-countdown reset of f4 (sb[4]=5 at reset edge).
    step(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);

    // Integer load to r8, then idle; then fw_stall on r9.
    step(1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Long FP write to f2, then a reader of f2 held until it clears.
    step(1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    stall_cnt = 0;
    wait_cnt  = 0;
    do begin
      step(1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 2'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      wait_cnt++;
    end while (stall_cnt == wait_cnt && wait_cnt < 20);
    n_checks++;
    if (stall_cnt != LONG_LAT) begin
      n_fail++;
      $display("FAIL long_stall_len got %0d exp %0d", stall_cnt, LONG_LAT);
    end
    idle(3);

    // Short FP write f3 followed by a WAW write to f3.
    step(1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (stall_cnt != SHORT_LAT) begin
      n_fail++;
      $display("FAIL waw_stall_len got %0d exp %0d", stall_cnt, SHORT_LAT);
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flushed FP write to f5 must not mark it pending; FP reg 0 is tracked.
    step(1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
    end
    idle(2);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
